// File: rtl/cpu_fetch_if.sv
// cpu_fetch_if: instruction-memory request/response bus between the fetch stage and memory
//   req   : one-cycle fetch request pulse (fetch -> memory)
//   addr  : fetch address, valid with req (fetch -> memory)
//   rdata : returned instruction (memory -> fetch)
//   vld   : response strobe for the single outstanding request (memory -> fetch)
interface cpu_fetch_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic [INSTR_W-1:0] rdata;
  logic               vld;
  modport master (output req, addr, input rdata, vld);
  modport slave  (input req, addr, output rdata, vld);
endinterface

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction-fetch stage with one request in flight, one buffered response and the IF/DEC register
//   clk, rst_n    : core clock, asynchronous active-low reset
//   rd_wrt_stall  : RAW hazard stall, holds IF register and PC
//   jb_stall      : unresolved jump/branch, stops issuing and emits bubbles
//   br_taken      : one-cycle redirect pulse, br_target carries the new PC
//   imem          : instruction-memory bus (master side)
//   if_instr/if_pc/if_vld : IF/DEC pipeline register
module cpu_fetch #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_wrt_stall,
  input  logic               jb_stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  cpu_fetch_if.master        imem,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_vld
);
  typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_WAIT, S_FULL} state_t;
  state_t             r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [PC_W-1:0]    r_req_pc, w_req_pc_nxt;
  logic [PC_W-1:0]    r_addr, w_addr_nxt;
  logic [PC_W-1:0]    r_if_pc, w_if_pc_nxt;
  logic [INSTR_W-1:0] r_buf, w_buf_nxt;
  logic [INSTR_W-1:0] r_if_instr, w_if_instr_nxt;
  logic               r_req, w_req_nxt;
  logic               r_drop, w_drop_nxt;
  logic               r_if_vld, w_if_vld_nxt;
  logic               w_advance;
  logic               w_new_vld;
  logic [INSTR_W-1:0] w_new_instr;
  always_comb begin
    w_advance   = !rd_wrt_stall && !jb_stall;
    // a fresh instruction is either the live response (unless it is stale or being redirected) or the buffered one
    w_new_vld   = (r_state == S_WAIT && imem.vld && !r_drop && !br_taken) || r_state == S_FULL;
    w_new_instr = r_state == S_FULL ? r_buf : imem.rdata;
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_addr_nxt  = r_addr;
    w_buf_nxt   = r_buf;
    w_req_nxt   = 1'b0;
    w_drop_nxt  = r_drop;
    unique case (r_state)
      S_BOOT: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (br_taken) w_pc_nxt = br_target;
        else if (w_advance) begin
          w_req_nxt    = 1'b1;
          w_addr_nxt   = r_pc;
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + PC_W'(PC_INC);
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.vld) begin
          w_drop_nxt  = 1'b0;
          w_pc_nxt    = br_taken ? br_target : r_pc;
          w_state_nxt = (r_drop || br_taken || w_advance) ? S_ISSUE : S_FULL;
          w_buf_nxt   = (!r_drop && !br_taken && !w_advance) ? imem.rdata : r_buf;
        end else if (br_taken) begin
          // the in-flight response now belongs to the old path; remember to throw it away
          w_pc_nxt   = br_target;
          w_drop_nxt = 1'b1;
        end
      end
      S_FULL: begin
        w_pc_nxt    = br_taken ? br_target : r_pc;
        w_state_nxt = (br_taken || w_advance) ? S_ISSUE : S_FULL;
      end
    endcase
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = '0;
    w_if_vld_nxt   = 1'b0;
    if (!br_taken && rd_wrt_stall) begin
      w_if_instr_nxt = r_if_instr;
      w_if_vld_nxt   = r_if_vld;
    end else if (!br_taken && w_new_vld && !jb_stall) begin
      w_if_instr_nxt = w_new_instr;
      w_if_pc_nxt    = r_req_pc;
      w_if_vld_nxt   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_addr     <= '0;
      r_buf      <= '0;
      r_req      <= 1'b0;
      r_drop     <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= RESET_PC;
      r_if_vld   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_buf      <= w_buf_nxt;
      r_req      <= w_req_nxt;
      r_drop     <= w_drop_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_vld   <= w_if_vld_nxt;
    end
  end
  assign imem.req  = r_req;
  assign imem.addr = r_addr;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign if_vld    = r_if_vld;
endmodule
